// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Returns read data or a timeout error on a valid/ready response port.
module wb_cmd_master #(
    parameter int ADDRWIDTH      = 7,
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    input  logic [3:0]           cmd_byte_stb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [7:0]           err_cnt_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic                 WBm_WE_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign cmd_ready_o = (state == IDLE) & ~WBs_RST_i;

    // ACK has priority over an expiring timeout in the same cycle
    assign tmo_hit = ~WBm_ACK_i & (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_valid_i) state_nxt = BUS;
            BUS:     if (WBm_ACK_i | tmo_hit) state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            WBm_ADR_o      <= '0;
            WBm_DAT_o      <= '0;
            WBm_BYTE_STB_o <= '0;
            WBm_WE_o       <= 1'b0;
            WBm_CYC_o      <= 1'b0;
            WBm_STB_o      <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_dat_o      <= '0;
            rsp_err_o      <= 1'b0;
            err_cnt_o      <= '0;
            tmo_cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        WBm_ADR_o      <= cmd_adr_i;
                        WBm_DAT_o      <= cmd_dat_i;
                        WBm_BYTE_STB_o <= cmd_byte_stb_i;
                        WBm_WE_o       <= cmd_we_i;
                        WBm_CYC_o      <= 1'b1;
                        WBm_STB_o      <= 1'b1;
                        tmo_cnt        <= '0;
                    end
                end
                BUS: begin
                    if (WBm_ACK_i) begin
                        WBm_CYC_o   <= 1'b0;
                        WBm_STB_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_dat_o   <= WBm_WE_o ? '0 : WBm_DAT_i;
                    end else if (tmo_hit) begin
                        WBm_CYC_o   <= 1'b0;
                        WBm_STB_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                        err_cnt_o   <= err_cnt_o + {7'd0, ~&err_cnt_o};
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) rsp_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-transfer initiator that sits in front of the FPGA register fabric (the same Wishbone interface the register files serve). It accepts one read or write command at a time on a valid/ready command port and runs the bus cycle. It returns read data or a timeout error on a valid/ready response port. On-FPGA sequencers use it to program and poll registers without the ASSP host.

## Interface
- ADDRWIDTH, 7: word address width of WBm_ADR_o.
- DATAWIDTH, 32: data bus width.
- TIMEOUT_CYCLES, 255: maximum STB-high cycles without ACK before abort; range 1..65535.
- WBs_CLK_i  in  1  block clock; all logic on the rising edge.
- WBs_RST_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDRWIDTH  word address.
- cmd_dat_i  in  DATAWIDTH  write data.
- cmd_byte_stb_i  in  4  byte enables.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid & ready.
- rsp_dat_o  out  DATAWIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = timeout.
- err_cnt_o  out  8  saturating count of timeouts since reset.
- WBm_ADR_o, WBm_DAT_o, WBm_BYTE_STB_o, WBm_WE_o, WBm_CYC_o, WBm_STB_o  out  ADDRWIDTH / DATAWIDTH / 4 / 1 / 1 / 1  bus request.
- WBm_DAT_i  in  DATAWIDTH  read data bus.
- WBm_ACK_i  in  1  transfer acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- cmd_ready_o = (state == IDLE) & ~WBs_RST_i.
- IDLE: on handshake, register cmd_adr_i, cmd_dat_i, cmd_byte_stb_i and cmd_we_i onto the WBm_* outputs. Set CYC and STB. Clear the timeout counter. Go to BUS.
- BUS: CYC, STB and all request fields are held stable. Each cycle, sample WBm_ACK_i.
  - ACK = 1: capture WBm_DAT_i into rsp_dat_o for a read, or 0 for a write. Set rsp_err_o = 0. Drop CYC and STB. Go to RESP.
  - ACK = 0: increment the 16-bit timeout counter. When the counter reaches TIMEOUT_CYCLES-1 in the same cycle, abort: drop CYC and STB, set rsp_dat_o = 0 and rsp_err_o = 1, increment err_cnt_o (saturates at 255), and go to RESP.
  - ACK and the timeout condition in the same cycle: ACK wins and no error is raised.
- RESP: rsp_valid_o = 1, with rsp_dat_o and rsp_err_o held stable until rsp_ready_i. On the handshake, go to IDLE. The next command can be accepted on the following cycle.
- WBm_ACK_i is ignored outside BUS.
- WBm_WE_o, WBm_ADR_o, WBm_DAT_o and WBm_BYTE_STB_o keep their last values after a transfer. Only CYC and STB return to 0.
- Reset at any time, including mid-BUS or mid-RESP: all outputs take their reset values at the next edge. The in-flight transfer is discarded with no response.
- Reset values: CYC, STB, WE = 0; ADR, DAT_o, BYTE_STB = 0; rsp_valid_o = 0; rsp_dat_o = 0; rsp_err_o = 0; err_cnt_o = 0; timeout counter = 0.

## Timing
- All outputs except cmd_ready_o are registered.
- Command handshake at edge E0: CYC and STB are high in the cycle after E0.
- ACK high in cycle N of STB, where N = 1 is the first STB cycle: CYC and STB are low and rsp_valid_o is high in the cycle after.
- With the team's registered-ACK slaves (ACK one cycle after STB, gated by ~ACK), N = 2. Command to rsp_valid_o therefore takes 3 cycles, and STB is dropped before the slave can re-ACK.
- Timeout: STB stays high for exactly TIMEOUT_CYCLES cycles, then rsp_valid_o rises on the next cycle.
- Minimum command-to-command spacing is 4 cycles when rsp_ready_i is tied high.

## Test plan
- Write: a slave with 1-cycle registered ACK receives cmd adr 0x02, dat 0x0000_1234, stb 0xF, we 1. Required: STB high for exactly 2 cycles with stable fields, then rsp_valid 3 cycles after accept with rsp_dat 0 and rsp_err 0.
- Read: the slave returns 0x0000A5BD at adr 0x00. Required: rsp_dat 0x0000A5BD, rsp_err 0, CYC and STB low on the cycle after ACK.
- Timeout: TIMEOUT_CYCLES = 4, ACK tied low. Required: STB high for exactly 4 cycles, then rsp_err 1, rsp_dat 0, err_cnt 1. Repeat 300 times; err_cnt must saturate at 255.
- ACK arriving on the 4th STB cycle with TIMEOUT_CYCLES = 4. Required: rsp_err 0, data captured, err_cnt unchanged.
- Back-pressure: hold rsp_ready low for 10 cycles. Required: rsp_valid and rsp_dat stable, cmd_ready low, no bus activity. Release, then accept a new command the next cycle.
- Reset asserted during BUS, and again during RESP. Required: all outputs at reset values after the next edge, no response emitted, and the next command completes normally.
